// File: rtl/pipeline_mem_stage.sv
// Memory-access stage with req/ack data bus, lane alignment and MEM/WB register.
// Optional misalignment trap: define MEM_MISALIGN_TRAP_EN to add misalign_out.
module pipeline_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_enable_in,
    input  logic        dmem_write_enable_in,
    input  logic [1:0]  dmem_type_in,
    input  logic [31:0] rt_data_in,
    input  logic [31:0] alu_result_in,
    input  logic [4:0]  rd_write_address_in,
    input  logic        rd_select_in,
    input  logic        rd_write_enable_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_byte_en,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [4:0]  rd_write_address_out,
    output logic        rd_write_enable_out,
    output logic [31:0] rd_data_out,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_out,
`endif
    output logic        bus_error_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [7:0]  count;
    logic        timeout_hit;
    logic        misaligned;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [15:0] half;
    logic [7:0]  byte_lane;
    logic [31:0] load_data;

    assign timeout_hit = (count == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        case (dmem_type_in)
            2'b00:   misaligned = (alu_result_in[1:0] != 2'b00);
            2'b01:   misaligned = alu_result_in[0];
            default: misaligned = 1'b0;
        endcase
`endif
    end

    // Lane selection is shared by store byte enables and load extraction.
    always_comb begin
        byte_en = 4'b1111;
        wdata   = rt_data_in;
        case (dmem_type_in)
            2'b00: begin
                byte_en = 4'b1111;
                wdata   = rt_data_in;
            end
            2'b01: begin
                byte_en = alu_result_in[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{rt_data_in[15:0]}};
            end
            default: begin
                byte_en = 4'b0001 << alu_result_in[1:0];
                wdata   = {4{rt_data_in[7:0]}};
            end
        endcase
    end

    always_comb begin
        half = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (alu_result_in[1:0])
            2'b00:   byte_lane = dmem_rdata[7:0];
            2'b01:   byte_lane = dmem_rdata[15:8];
            2'b10:   byte_lane = dmem_rdata[23:16];
            default: byte_lane = dmem_rdata[31:24];
        endcase
        case (dmem_type_in)
            2'b00:   load_data = dmem_rdata;
            2'b01:   load_data = {{16{half[15]}}, half};
            2'b10:   load_data = {{24{byte_lane[7]}}, byte_lane};
            default: load_data = {24'd0, byte_lane};
        endcase
    end

    // The final timeout cycle releases stall so the dropped instruction leaves.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            case (state)
                IDLE:   stall = dmem_enable_in && !misaligned;
                ACCESS: stall = !dmem_ack && !timeout_hit;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state                <= IDLE;
            count                <= 8'd0;
            dmem_req             <= 1'b0;
            dmem_we              <= 1'b0;
            dmem_addr            <= 32'd0;
            dmem_byte_en         <= 4'd0;
            dmem_wdata           <= 32'd0;
            rd_write_address_out <= 5'd0;
            rd_write_enable_out  <= 1'b0;
            rd_data_out          <= 32'd0;
            bus_error_out        <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_out         <= 1'b0;
`endif
        end else begin
            bus_error_out <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_out  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    rd_write_address_out <= rd_write_address_in;
                    rd_data_out          <= alu_result_in;
                    if (dmem_enable_in && !misaligned) begin
                        state               <= ACCESS;
                        count               <= 8'd0;
                        dmem_req            <= 1'b1;
                        dmem_we             <= dmem_write_enable_in;
                        dmem_addr           <= {alu_result_in[31:2], 2'b00};
                        dmem_byte_en        <= byte_en;
                        dmem_wdata          <= wdata;
                        rd_write_enable_out <= 1'b0;
                    end else begin
                        rd_write_enable_out <= rd_write_enable_in && !dmem_enable_in;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_out        <= dmem_enable_in;
`endif
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        state                <= IDLE;
                        dmem_req             <= 1'b0;
                        rd_write_address_out <= rd_write_address_in;
                        rd_write_enable_out  <= rd_write_enable_in;
                        rd_data_out          <= rd_select_in ? load_data : alu_result_in;
                    end else if (timeout_hit) begin
                        state               <= IDLE;
                        dmem_req            <= 1'b0;
                        bus_error_out       <= 1'b1;
                        rd_write_enable_out <= 1'b0;
                    end else begin
                        count               <= count + 8'd1;
                        rd_write_enable_out <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Randomized bench for pipeline_mem_stage with a lane-arithmetic reference model.
module tb_pipeline_mem_stage;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        dmem_enable_in, dmem_write_enable_in, rd_select_in, rd_write_enable_in;
    logic [1:0]  dmem_type_in;
    logic [31:0] rt_data_in, alu_result_in, dmem_rdata;
    logic [4:0]  rd_write_address_in;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, rd_write_enable_out, bus_error_out;
    logic [31:0] dmem_addr, dmem_wdata, rd_data_out;
    logic [3:0]  dmem_byte_en;
    logic [4:0]  rd_write_address_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .dmem_enable_in(dmem_enable_in), .dmem_write_enable_in(dmem_write_enable_in),
        .dmem_type_in(dmem_type_in), .rt_data_in(rt_data_in), .alu_result_in(alu_result_in),
        .rd_write_address_in(rd_write_address_in), .rd_select_in(rd_select_in),
        .rd_write_enable_in(rd_write_enable_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_byte_en(dmem_byte_en), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
        .rd_write_address_out(rd_write_address_out), .rd_write_enable_out(rd_write_enable_out),
        .rd_data_out(rd_data_out),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_out(misalign_out),
`endif
        .bus_error_out(bus_error_out)
    );

    // Reference model: lanes derived from address arithmetic.
    function automatic logic [3:0] exp_be(input logic [1:0] ty, input logic [31:0] addr);
        case (ty)
            2'b00:   return 4'b1111;
            2'b01:   return 4'b0011 << (addr[1] ? 2 : 0);
            default: return 4'b0001 << addr[1:0];
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] ty, input logic [31:0] rt);
        case (ty)
            2'b00:   return rt;
            2'b01:   return {16'd0, rt[15:0]} * 32'h0001_0001;
            default: return {24'd0, rt[7:0]} * 32'h0101_0101;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] ty, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        logic signed [15:0] h;
        logic signed [7:0]  b;
        int sh;
        sh = (ty == 2'b01) ? (addr[1] ? 16 : 0) : 8 * int'(addr[1:0]);
        v = rdata >> sh;
        h = v[15:0];
        b = v[7:0];
        case (ty)
            2'b00:   return rdata;
            2'b01:   return int'(h);
            2'b10:   return int'(b);
            default: return v & 32'hFF;
        endcase
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        dmem_enable_in = 0; dmem_write_enable_in = 0; dmem_type_in = 0; rt_data_in = 0;
        alu_result_in = 0; rd_write_address_in = 0; rd_select_in = 0; rd_write_enable_in = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic do_mem(input logic wr, input logic [1:0] ty, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [4:0] rd, input logic sel,
                          input logic rwe, input int waits, input logic [31:0] rdata);
        logic [31:0] exp_data;
        dmem_enable_in = 1; dmem_write_enable_in = wr; dmem_type_in = ty; rt_data_in = rt;
        alu_result_in = addr; rd_write_address_in = rd; rd_select_in = sel;
        rd_write_enable_in = rwe; dmem_ack = 0; dmem_rdata = 32'hDEAD_0000;
        #1;
        checks++;
        if ({stall, dmem_req} !== 2'b10)
            begin errors++; $display("FAIL idle_stall_req got %b want 10", {stall, dmem_req}); end
        step;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_byte_en, dmem_wdata} !==
            {1'b1, wr, {addr[31:2], 2'b00}, exp_be(ty, addr), exp_wdata(ty, rt)}) begin
            errors++;
            $display("FAIL bus got req=%b we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                     dmem_req, dmem_we, dmem_addr, dmem_byte_en, dmem_wdata, wr,
                     {addr[31:2], 2'b00}, exp_be(ty, addr), exp_wdata(ty, rt));
        end
        checks++;
        if (rd_write_enable_out !== 1'b0)
            begin errors++; $display("FAIL access_bubble got %b want 0", rd_write_enable_out); end
        for (int i = 0; i < waits; i++) begin
            #1;
            checks++;
            if (stall !== 1'b1)
                begin errors++; $display("FAIL wait_stall cycle %0d got %b want 1", i, stall); end
            step;
            checks++;
            if ({dmem_req, rd_write_enable_out} !== 2'b10)
                begin errors++; $display("FAIL wait_hold got %b want 10", {dmem_req, rd_write_enable_out}); end
        end
        dmem_ack = 1; dmem_rdata = rdata;
        #1;
        checks++;
        if (stall !== 1'b0)
            begin errors++; $display("FAIL ack_stall got %b want 0", stall); end
        step;
        idle_inputs();
        exp_data = sel ? exp_load(ty, addr, rdata) : addr;
        checks++;
        if ({dmem_req, bus_error_out, rd_write_address_out, rd_write_enable_out, rd_data_out} !==
            {1'b0, 1'b0, rd, rwe, exp_data}) begin
            errors++;
            $display("FAIL mem_wb got req=%b err=%b rd=%0d we=%b data=%h want rd=%0d we=%b data=%h",
                     dmem_req, bus_error_out, rd_write_address_out, rd_write_enable_out,
                     rd_data_out, rd, rwe, exp_data);
        end
    endtask

    task automatic do_nonmem(input logic [31:0] val, input logic [4:0] rd, input logic rwe);
        dmem_enable_in = 0; rd_select_in = 0; alu_result_in = val;
        rd_write_address_in = rd; rd_write_enable_in = rwe; dmem_ack = $urandom_range(0, 1);
        #1;
        checks++;
        if (stall !== 1'b0)
            begin errors++; $display("FAIL nonmem_stall got %b want 0", stall); end
        step;
        checks++;
        if ({rd_write_address_out, rd_write_enable_out, rd_data_out, dmem_req} !== {rd, rwe, val, 1'b0})
            begin
                errors++;
                $display("FAIL nonmem got rd=%0d we=%b data=%h req=%b want rd=%0d we=%b data=%h",
                         rd_write_address_out, rd_write_enable_out, rd_data_out, dmem_req, rd, rwe, val);
            end
`ifdef MEM_MISALIGN_TRAP_EN
        checks++;
        if (misalign_out !== 1'b0)
            begin errors++; $display("FAIL nonmem_misalign got %b want 0", misalign_out); end
`endif
        dmem_ack = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        idle_inputs();
        dmem_enable_in = 1; alu_result_in = 32'h100;
        step; step;
        checks++;
        if ({stall, dmem_req, dmem_we, dmem_addr, dmem_byte_en, dmem_wdata, rd_write_address_out,
             rd_write_enable_out, rd_data_out, bus_error_out} !== '0)
            begin errors++; $display("FAIL reset_state stall=%b req=%b data=%h want all 0", stall, dmem_req, rd_data_out); end
        reset = 1;
        idle_inputs();
        step;
    endtask

    task automatic test_non_mem;
        do_nonmem(32'h1234, 5'd5, 1'b1);
        do_nonmem(32'hFFFF_0000, 5'd31, 1'b0);
    endtask

    task automatic test_word_load;
        do_mem(1'b0, 2'b00, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 2, 32'hCAFE_BABE);
        checks++;
        if (rd_data_out !== 32'hCAFE_BABE)
            begin errors++; $display("FAIL word_load got %h want cafebabe", rd_data_out); end
    endtask

    task automatic test_byte_store_load;
        do_mem(1'b1, 2'b10, 32'h203, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 0, 32'h0);
        do_mem(1'b0, 2'b10, 32'h203, 32'h0, 5'd9, 1'b1, 1'b1, 1, 32'h80FF_FFFF);
        checks++;
        if (rd_data_out !== 32'hFFFF_FF80)
            begin errors++; $display("FAIL sbyte_load got %h want ffffff80", rd_data_out); end
        do_mem(1'b0, 2'b11, 32'h203, 32'h0, 5'd9, 1'b1, 1'b1, 0, 32'h80FF_FFFF);
        checks++;
        if (rd_data_out !== 32'h0000_0080)
            begin errors++; $display("FAIL ubyte_load got %h want 00000080", rd_data_out); end
    endtask

    task automatic test_timeout;
        int req_cycles = 0;
        idle_inputs();
        dmem_enable_in = 1; alu_result_in = 32'h40; rd_write_address_in = 3;
        rd_select_in = 1; rd_write_enable_in = 1;
        step;
        for (int c = 0; c < 40; c++) begin
            if (!dmem_req) break;
            req_cycles++;
            #1;
            checks++;
            if (stall !== (req_cycles < TO))
                begin errors++; $display("FAIL timeout_stall cycle %0d got %b want %b", req_cycles, stall, req_cycles < TO); end
            if (req_cycles >= TO) idle_inputs();
            step;
        end
        checks++;
        if (req_cycles != TO)
            begin errors++; $display("FAIL timeout_len got %0d want %0d", req_cycles, TO); end
        idle_inputs();
        checks++;
        if ({bus_error_out, rd_write_enable_out, stall} !== 3'b100)
            begin errors++; $display("FAIL timeout_err got %b want 100", {bus_error_out, rd_write_enable_out, stall}); end
        step;
        checks++;
        if (bus_error_out !== 1'b0)
            begin errors++; $display("FAIL err_pulse got %b want 0", bus_error_out); end
        // Ack on the last allowed cycle completes normally.
        do_mem(1'b0, 2'b00, 32'h44, 32'h0, 5'd4, 1'b1, 1'b1, TO - 1, 32'h1357_9BDF);
    endtask

    task automatic test_reset_mid_access;
        idle_inputs();
        dmem_enable_in = 1; alu_result_in = 32'h80; rd_write_address_in = 6;
        rd_select_in = 1; rd_write_enable_in = 1;
        step; step;
        reset = 0;
        #1;
        checks++;
        if (stall !== 1'b0)
            begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        step;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_byte_en, dmem_wdata, rd_write_address_out,
             rd_write_enable_out, rd_data_out, bus_error_out} !== '0)
            begin errors++; $display("FAIL reset_mid req=%b addr=%h err=%b want all 0", dmem_req, dmem_addr, bus_error_out); end
        reset = 1;
        idle_inputs();
        step;
        checks++;
        if ({dmem_req, bus_error_out} !== 2'b00)
            begin errors++; $display("FAIL post_reset got %b want 00", {dmem_req, bus_error_out}); end
        do_mem(1'b0, 2'b01, 32'h86, 32'h0, 5'd6, 1'b1, 1'b1, 1, 32'h8001_7FFF);
    endtask

    task automatic test_back_to_back;
        do_mem(1'b1, 2'b01, 32'h302, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 0, 32'h0);
        do_mem(1'b0, 2'b01, 32'h302, 32'h0, 5'd12, 1'b1, 1'b1, 0, 32'h5678_0000);
        do_mem(1'b0, 2'b00, 32'h304, 32'h0, 5'd13, 1'b1, 1'b1, 0, 32'hA5A5_1234);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] addr;
            logic [1:0]  ty;
            logic        wr;
            addr = $urandom;
            ty = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            if (ty == 2'b00) addr[1:0] = 2'b00;
            if (ty == 2'b01) addr[0] = 1'b0;
            if ($urandom_range(0, 2) == 0)
                do_nonmem($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            else
                do_mem(wr, ty, addr, $urandom, 5'($urandom_range(0, 31)), !wr, !wr,
                       $urandom_range(0, 3), $urandom);
        end
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign;
        idle_inputs();
        dmem_enable_in = 1; dmem_type_in = 2'b01; alu_result_in = 32'h101;
        rd_write_address_in = 8; rd_select_in = 1; rd_write_enable_in = 1;
        #1;
        checks++;
        if (stall !== 1'b0)
            begin errors++; $display("FAIL misalign_stall got %b want 0", stall); end
        step;
        checks++;
        if ({dmem_req, misalign_out, rd_write_enable_out} !== 3'b010)
            begin errors++; $display("FAIL misalign_half got %b want 010", {dmem_req, misalign_out, rd_write_enable_out}); end
        dmem_type_in = 2'b00; alu_result_in = 32'h102;
        step;
        checks++;
        if ({dmem_req, misalign_out, rd_write_enable_out} !== 3'b010)
            begin errors++; $display("FAIL misalign_word got %b want 010", {dmem_req, misalign_out, rd_write_enable_out}); end
        idle_inputs();
        do_mem(1'b0, 2'b01, 32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 0, 32'hBEEF_0000);
        checks++;
        if (misalign_out !== 1'b0)
            begin errors++; $display("FAIL aligned_flag got %b want 0", misalign_out); end
    endtask
`else
    task automatic test_ignored_bits;
        do_mem(1'b0, 2'b01, 32'h101, 32'h0, 5'd8, 1'b1, 1'b1, 0, 32'h1234_ABCD);
        checks++;
        if ({dmem_byte_en, rd_data_out} !== {4'b0011, 32'hFFFF_ABCD})
            begin errors++; $display("FAIL half_ignore got be=%b data=%h want 0011 ffffabcd", dmem_byte_en, rd_data_out); end
        do_mem(1'b0, 2'b00, 32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 0, 32'h0BAD_F00D);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_non_mem();
        test_word_load();
        test_byte_store_load();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`else
        test_ignored_bits();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
